// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encoding, byte-port width and default bit timing.
// Kept separate so the UART receiver can import the same encodings.
package uart_tx_pkg;

  localparam int UART_OPT_BYTE_W           = 9;
  localparam int UART_DATA_W               = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core write port and the transmit FSM.
// Push is ignored when full and pop is ignored when empty; the count is registered.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   push_i,
  input  logic [UART_DATA_W-1:0] push_data_i,
  input  logic                   pop_i,
  output logic [UART_DATA_W-1:0] pop_data_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push_ok;
  logic                   pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == {CNT_W{1'b0}});
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers core bytes in a FIFO and sends them as 8N1/8N2 frames, LSB first.
// line_out comes straight from a register so the serial line never glitches.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [UART_OPT_BYTE_W-1:0] wr_opt_byte,
  output logic                       wr_ready,
  output logic                       line_out,
  output logic                       busy
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (!is_pow2(DEPTH)) begin : g_chk_depth
    $error("uart_tx: DEPTH must be a power of two >= 2");
  end

  uart_state_e            state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   line_q, line_d;

  logic                   fifo_pop;
  logic [UART_DATA_W-1:0] fifo_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   baud_last;
  logic                   stop_last;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .push_i      (wr_opt_byte[UART_OPT_BYTE_W-1]),
    .push_data_i (wr_opt_byte[UART_DATA_W-1:0]),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;
  assign wr_ready  = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign line_out  = line_q;

  // Frame sequencing; the line level is chosen from the next state so it is registered in step.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    stop_idx_d = stop_idx_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_data;
          baud_d    = {BAUD_W{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = {BAUD_W{1'b0}};
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d    = {BAUD_W{1'b0}};
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            state_d    = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = {BAUD_W{1'b0}};
          if (stop_last) begin
            // Chain straight into the next start bit when another byte is waiting.
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              shift_d   = fifo_data;
              bit_idx_d = 3'd0;
              state_d   = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = {BAUD_W{1'b0}};
      end
    endcase

    case (state_d)
      ST_START: line_d = 1'b0;
      ST_DATA:  line_d = shift_d[0];
      default:  line_d = 1'b1;
    endcase
  end

  // FSM, baud counter, shift register and line register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      baud_q     <= {BAUD_W{1'b0}};
      bit_idx_q  <= 3'd0;
      shift_q    <= {UART_DATA_W{1'b0}};
      stop_idx_q <= 1'b0;
      line_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      stop_idx_q <= stop_idx_d;
      line_q     <= line_d;
    end
  end

endmodule
